// File: rtl/nms_window_sequencer.sv
// Raster-scan window builder for non-max suppression: two line buffers plus a
// 3x3 shift window, emitting one registered window per interior pixel.
module nms_window_sequencer #(
  parameter  int IMG_WIDTH  = 512,
  parameter  int IMG_HEIGHT = 512,
  parameter  int MAG_W      = 11,
  parameter  int DIR_W      = 2,
  localparam int CW         = $clog2(IMG_WIDTH),
  localparam int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [MAG_W-1:0]   in_mag,
  input  logic [DIR_W-1:0]   in_dir,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*MAG_W-1:0] win_mag,
  output logic [9*DIR_W-1:0] win_dir,
  output logic [RW-1:0]      win_row,
  output logic [CW-1:0]      win_col,
  output logic               win_last,
  output logic               frame_done,
  output logic               err_sof
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [DIR_W-1:0] dir;
  } pix_t;

  state_t        state;
  logic [CW-1:0] col, pc;
  logic [RW-1:0] row, pr;
  logic          in_hs, out_hs, proc, load, is_eol, is_bot;
  pix_t          pix;
  pix_t          lb0 [IMG_WIDTH];
  pix_t          lb1 [IMG_WIDTH];
  pix_t          w   [3][3];
  pix_t          nw  [3][3];
  pix_t          cnew [3];

  assign in_ready = rst_n && (state != S_DONE) && (!win_valid || win_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = win_valid && win_ready;
  // IDLE swallows pixels until a start-of-frame shows up
  assign proc     = in_hs && ((state != S_IDLE) || in_sof);
  assign pc       = in_sof ? '0 : col;
  assign pr       = in_sof ? '0 : row;
  assign is_eol   = (pc == CW'(IMG_WIDTH - 1));
  assign is_bot   = (pr == RW'(IMG_HEIGHT - 1));
  assign load     = proc && (state == S_RUN) && !in_sof && (pc >= CW'(2));
  assign pix      = '{mag: in_mag, dir: in_dir};

  // Window after this pixel's shift; left columns restart at each row start.
  always_comb begin
    cnew[0] = lb1[pc];
    cnew[1] = lb0[pc];
    cnew[2] = pix;
    for (int i = 0; i < 3; i++) begin
      nw[i][0] = (pc == '0) ? '0 : w[i][1];
      nw[i][1] = (pc == '0) ? '0 : w[i][2];
      nw[i][2] = cnew[i];
    end
  end

  // lb0 keeps row r-1 and lb1 row r-2; shifting per column is the row rotation.
  always_ff @(posedge clk) begin
    if (proc) begin
      lb0[pc] <= pix;
      lb1[pc] <= lb0[pc];
      w       <= nw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_mag    <= '0;
      win_dir    <= '0;
      win_row    <= '0;
      win_col    <= '0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= out_hs && win_last;
      err_sof    <= in_hs && in_sof && ((state == S_FILL) || (state == S_RUN));

      if (proc) begin
        col <= is_eol ? '0 : pc + CW'(1);
        row <= is_eol ? pr + RW'(1) : pr;
        if (in_sof)
          state <= S_FILL;
        else if ((state == S_FILL) && is_eol && (pr == RW'(1)))
          state <= S_RUN;
        else if ((state == S_RUN) && is_eol && is_bot)
          state <= S_DONE;
      end else if ((state == S_DONE) && out_hs && win_last) begin
        state <= S_IDLE;
      end

      // a pending window survives a mid-frame restart until it handshakes
      if (load) begin
        win_valid <= 1'b1;
        win_row   <= pr - RW'(2);
        win_col   <= pc - CW'(2);
        win_last  <= is_eol && is_bot;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            win_mag[(i*3+j)*MAG_W +: MAG_W] <= nw[i][j].mag;
            win_dir[(i*3+j)*DIR_W +: DIR_W] <= nw[i][j].dir;
          end
        end
      end else if (out_hs) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nms_window_sequencer.sv
// Directed bench for nms_window_sequencer on a 5x4 frame with mag=r*5+c, dir=c%4.
module tb_nms_window_sequencer;
  localparam int W = 5, H = 4, MW = 11, DW = 2;

  logic            clk, rst_n;
  logic            in_valid, in_ready, in_sof;
  logic [MW-1:0]   in_mag;
  logic [DW-1:0]   in_dir;
  logic            win_valid, win_ready, win_last, frame_done, err_sof;
  logic [9*MW-1:0] win_mag;
  logic [9*DW-1:0] win_dir;
  logic [1:0]      win_row;
  logic [2:0]      win_col;

  nms_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW), .DIR_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_mag(in_mag), .in_dir(in_dir), .win_valid(win_valid), .win_ready(win_ready),
    .win_mag(win_mag), .win_dir(win_dir), .win_row(win_row), .win_col(win_col),
    .win_last(win_last), .frame_done(frame_done), .err_sof(err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  bit            q_sof [$];
  logic [MW-1:0] q_mag [$];
  logic [DW-1:0] q_dir [$];

  int              g_row [$];
  int              g_col [$];
  logic [9*MW-1:0] g_mag [$];
  logic [9*DW-1:0] g_dir [$];
  bit              g_last [$];
  int n_done, n_err, stall_bad, ready_bad, done_bad;
  bit timeout;

  function automatic void push_frame(int npix);
    for (int p = 0; p < npix; p++) begin
      q_sof.push_back(p == 0);
      q_mag.push_back(MW'(p));
      q_dir.push_back(DW'((p % W) % 4));
    end
  endfunction

  function automatic logic [9*MW-1:0] exp_mag(int r0, int c0);
    logic [9*MW-1:0] v;
    for (int k = 0; k < 9; k++) v[k*MW +: MW] = MW'((r0 + k/3) * W + c0 + k%3);
    return v;
  endfunction

  function automatic logic [9*DW-1:0] exp_dir(int c0);
    logic [9*DW-1:0] v;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'((c0 + k%3) % 4);
    return v;
  endfunction

  task automatic clear_obs();
    q_sof.delete(); q_mag.delete(); q_dir.delete();
    g_row.delete(); g_col.delete(); g_mag.delete(); g_dir.delete(); g_last.delete();
    n_done = 0; n_err = 0; stall_bad = 0; ready_bad = 0; done_bad = 0; timeout = 0;
  endtask

  // Streams the queued pixels and records handshaken windows; ready_mode 1 = 1 high / 2 low.
  task automatic run(input int ready_mode, input bit drain);
    int idx = 0, cyc = 0;
    bit prev_stall = 0, last_hs_prev = 0;
    logic [9*MW-1:0] pm = '0;
    logic [9*DW-1:0] pd = '0;
    logic [1:0] prow = '0;
    logic [2:0] pcol = '0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        n_done++;
        if (!last_hs_prev) done_bad++;
      end else if (last_hs_prev) done_bad++;
      if (err_sof) n_err++;
      if (prev_stall && (win_valid !== 1'b1 || win_mag !== pm || win_dir !== pd ||
                         win_row !== prow || win_col !== pcol)) stall_bad++;
      if (drain ? (frame_done === 1'b1) : (idx >= q_sof.size())) break;
      if (cyc > 400) begin timeout = 1; break; end
      win_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      in_valid  = idx < q_sof.size();
      in_sof    = in_valid ? q_sof[idx] : 1'b0;
      in_mag    = in_valid ? q_mag[idx] : '0;
      in_dir    = in_valid ? q_dir[idx] : '0;
      #1;
      if (win_valid && !win_ready && in_ready) ready_bad++;
      last_hs_prev = win_valid && win_ready && win_last;
      if (win_valid && win_ready) begin
        g_row.push_back(int'(win_row)); g_col.push_back(int'(win_col));
        g_mag.push_back(win_mag); g_dir.push_back(win_dir); g_last.push_back(win_last);
      end
      prev_stall = win_valid && !win_ready;
      pm = win_mag; pd = win_dir; prow = win_row; pcol = win_col;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({win_valid, in_ready, win_last, frame_done, err_sof, win_mag, win_dir, win_row, win_col} !== '0) begin
      fails++; $display("FAIL reset_outputs got v%b r%b l%b want all zero", win_valid, in_ready, win_last);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle got in_ready %b win_valid %b want 1 0", in_ready, win_valid);
    end
  endtask

  task automatic test_stream();
    clear_obs(); push_frame(W*H); run(0, 1);
    tests++;
    if (g_row.size() != 6 || timeout) begin
      fails++; $display("FAIL stream_count got %0d timeout %0d want 6 0", g_row.size(), timeout);
    end
    for (int i = 0; i < g_row.size() && i < 6; i++) begin
      tests++;
      if (g_row[i] != i/3 || g_col[i] != i%3 || g_mag[i] !== exp_mag(i/3, i%3) ||
          g_dir[i] !== exp_dir(i%3) || g_last[i] != (i == 5)) begin
        fails++;
        $display("FAIL stream_win%0d got r%0d c%0d mag %h dir %h last %0d want r%0d c%0d mag %h dir %h last %0d",
                 i, g_row[i], g_col[i], g_mag[i], g_dir[i], g_last[i], i/3, i%3,
                 exp_mag(i/3, i%3), exp_dir(i%3), i == 5);
      end
    end
    tests++;
    if (g_mag.size() > 0 && g_mag[0] !== {11'd12, 11'd11, 11'd10, 11'd7, 11'd6, 11'd5, 11'd2, 11'd1, 11'd0}) begin
      fails++; $display("FAIL stream_first_literal got %h", g_mag[0]);
    end
    tests++;
    if (n_done != 1 || done_bad != 0 || n_err != 0) begin
      fails++; $display("FAIL stream_done got done %0d bad %0d err %0d want 1 0 0", n_done, done_bad, n_err);
    end
  endtask

  task automatic test_stall();
    clear_obs(); push_frame(W*H); run(1, 1);
    tests++;
    if (g_row.size() != 6 || timeout) begin
      fails++; $display("FAIL stall_count got %0d timeout %0d want 6 0", g_row.size(), timeout);
    end
    for (int i = 0; i < g_row.size() && i < 6; i++) begin
      tests++;
      if (g_row[i] != i/3 || g_col[i] != i%3 || g_mag[i] !== exp_mag(i/3, i%3) ||
          g_dir[i] !== exp_dir(i%3) || g_last[i] != (i == 5)) begin
        fails++; $display("FAIL stall_win%0d got r%0d c%0d mag %h want r%0d c%0d mag %h",
                          i, g_row[i], g_col[i], g_mag[i], i/3, i%3, exp_mag(i/3, i%3));
      end
    end
    tests++;
    if (stall_bad != 0 || ready_bad != 0) begin
      fails++; $display("FAIL stall_hold got unstable %0d ready_leak %0d want 0 0", stall_bad, ready_bad);
    end
    tests++;
    if (n_done != 1 || done_bad != 0) begin
      fails++; $display("FAIL stall_done got %0d bad %0d want 1 0", n_done, done_bad);
    end
  endtask

  task automatic test_idle_discard();
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      q_sof.push_back(1'b0); q_mag.push_back(MW'(100 + p)); q_dir.push_back(DW'(p));
    end
    push_frame(W*H); run(0, 1);
    tests++;
    if (g_row.size() != 6 || n_err != 0 || n_done != 1 || timeout) begin
      fails++; $display("FAIL idle_count got win %0d err %0d done %0d want 6 0 1", g_row.size(), n_err, n_done);
    end
    for (int i = 0; i < g_row.size() && i < 6; i++) begin
      tests++;
      if (g_row[i] != i/3 || g_col[i] != i%3 || g_mag[i] !== exp_mag(i/3, i%3) ||
          g_dir[i] !== exp_dir(i%3) || g_last[i] != (i == 5)) begin
        fails++; $display("FAIL idle_win%0d got r%0d c%0d mag %h want r%0d c%0d mag %h",
                          i, g_row[i], g_col[i], g_mag[i], i/3, i%3, exp_mag(i/3, i%3));
      end
    end
  endtask

  task automatic test_mid_sof();
    clear_obs();
    push_frame(2*W + 3);  // pixels up to (2,2); the restart lands where (2,3) would be
    push_frame(W*H);
    run(0, 1);
    tests++;
    if (n_err != 1) begin
      fails++; $display("FAIL midsof_err got %0d pulses want 1", n_err);
    end
    tests++;
    if (g_row.size() != 7 || n_done != 1 || timeout) begin
      fails++; $display("FAIL midsof_count got win %0d done %0d want 7 1", g_row.size(), n_done);
    end
    for (int i = 0; i < g_row.size() && i < 7; i++) begin
      int e = (i == 0) ? 0 : i - 1;
      tests++;
      if (g_row[i] != e/3 || g_col[i] != e%3 || g_mag[i] !== exp_mag(e/3, e%3) ||
          g_last[i] != (i == 6)) begin
        fails++; $display("FAIL midsof_win%0d got r%0d c%0d mag %h last %0d want r%0d c%0d mag %h last %0d",
                          i, g_row[i], g_col[i], g_mag[i], g_last[i], e/3, e%3, exp_mag(e/3, e%3), i == 6);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_obs(); push_frame(2*W + 3); run(0, 0);
    tests++;
    if (win_valid !== 1'b1) begin
      fails++; $display("FAIL areset_pre got win_valid %b want 1", win_valid);
    end
    win_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({win_valid, in_ready, win_last, frame_done, err_sof, win_mag, win_dir, win_row, win_col} !== '0) begin
      fails++; $display("FAIL areset_outputs got v%b r%b mag %h want all zero", win_valid, in_ready, win_mag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs(); push_frame(W*H); run(0, 1);
    tests++;
    if (g_row.size() != 6 || n_done != 1 || n_err != 0 || timeout) begin
      fails++; $display("FAIL areset_count got win %0d done %0d err %0d want 6 1 0", g_row.size(), n_done, n_err);
    end
    for (int i = 0; i < g_row.size() && i < 6; i++) begin
      tests++;
      if (g_row[i] != i/3 || g_col[i] != i%3 || g_mag[i] !== exp_mag(i/3, i%3) ||
          g_dir[i] !== exp_dir(i%3) || g_last[i] != (i == 5)) begin
        fails++; $display("FAIL areset_win%0d got r%0d c%0d mag %h want r%0d c%0d mag %h",
                          i, g_row[i], g_col[i], g_mag[i], i/3, i%3, exp_mag(i/3, i%3));
      end
    end
  endtask

  task automatic test_negative_mag();
    logic [9*MW-1:0] e;
    clear_obs(); push_frame(W*H);
    q_mag[W + 1] = 11'h400;
    run(0, 1);
    e = exp_mag(0, 0);
    e[4*MW +: MW] = 11'h400;
    tests++;
    if (g_mag.size() != 6 || g_mag[0] !== e) begin
      fails++; $display("FAIL negmag_win0 got n%0d mag %h want n6 mag %h", g_mag.size(), g_mag[0], e);
    end
    e = exp_mag(0, 1);
    e[3*MW +: MW] = 11'h400;
    tests++;
    if (g_mag.size() > 1 && g_mag[1] !== e) begin
      fails++; $display("FAIL negmag_win1 got %h want %h", g_mag[1], e);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_mag = '0; in_dir = '0; win_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_idle_discard();
    test_mid_sof();
    test_async_reset();
    test_negative_mag();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
